// File: rtl/backend_seq.sv
// ---------------------------------------------------------------------------
// backend_seq
//   Execution backend behind an instruction fetch unit. It takes one
//   instruction at a time over a ready/deque handshake and executes an
//   8-op ISA on a small register file. Taken branches and JR are reported
//   to fetch as one-cycle restart pulses. Loads and stores go to a data
//   memory that may refuse a request; a bounded number of refusals is
//   tolerated before the core halts with an error.
//
// Ports
//   clk, reset_i            clock; asynchronous active-high reset
//   instruction_*_i         instruction word, its address and a valid flag
//   deque_o                 instruction retired, fetch may advance
//   restart_o/_addr_o       flush fetch and restart at the given address
//   mem_req_o/we/addr/wdata data memory request (held stable while pending)
//   mem_rdata_i             load data, one cycle after an accepted load
//   mem_refused_i           same-cycle refusal of mem_req_o
//   dbg_ra_i / dbg_rd_o     combinational register file peek
//   halted_o / error_o      sticky halt, sticky retry-exhaustion error
//   retired_o               retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module backend_seq #(
  parameter int I_WIDTH   = 12,
  parameter int IA_WIDTH  = 8,
  parameter int D_WIDTH   = 16,
  parameter int RA_W      = 3,
  parameter int MA_W      = 10,
  parameter int MAX_RETRY = 4,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic [I_WIDTH-1:0]  instruction_data_i,
  input  logic [IA_WIDTH-1:0] instruction_addr_i,
  input  logic                instruction_ready_i,
  output logic                deque_o,
  output logic                restart_o,
  output logic [IA_WIDTH-1:0] restart_addr_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [MA_W-1:0]     mem_addr_o,
  output logic [D_WIDTH-1:0]  mem_wdata_o,
  input  logic [D_WIDTH-1:0]  mem_rdata_i,
  input  logic                mem_refused_i,
  input  logic [RA_W-1:0]     dbg_ra_i,
  output logic [D_WIDTH-1:0]  dbg_rd_o,
  output logic                halted_o,
  output logic                error_o,
  output logic [CNT_W-1:0]    retired_o
);

  localparam int NUM_REGS = 2 ** RA_W;
  localparam int IMM_W    = I_WIDTH - 3 - 2 * RA_W;
  localparam int RT_W     = $clog2(MAX_RETRY + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LD   = 3'b010;
  localparam logic [2:0] OP_ST   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_BLT  = 3'b101;
  localparam logic [2:0] OP_JR   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [D_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [D_WIDTH-1:0]  regs_d [NUM_REGS];
  logic [MA_W-1:0]     addr_q, addr_d;
  logic [D_WIDTH-1:0]  wdata_q, wdata_d;
  logic [RA_W-1:0]     ld_rd_q, ld_rd_d;
  logic                we_q, we_d;
  logic [RT_W-1:0]     retry_q, retry_d;
  logic                error_q, error_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  // Instruction field decode
  logic [2:0]          op;
  logic [RA_W-1:0]     rd_a, rs_a;
  logic [IMM_W-1:0]    imm;
  logic [D_WIDTH-1:0]  imm_sext;
  logic [IA_WIDTH-1:0] br_off;
  logic [D_WIDTH-1:0]  rd_val, rs_val;
  logic [MA_W-1:0]     mem_ea;
  logic [RT_W-1:0]     retry_inc;

  // Single register-file write port, shared by ALU ops and load return
  logic                reg_we;
  logic [RA_W-1:0]     reg_wa;
  logic [D_WIDTH-1:0]  reg_wd;

  assign op       = instruction_data_i[I_WIDTH-1 -: 3];
  assign rd_a     = instruction_data_i[I_WIDTH-4 -: RA_W];
  assign rs_a     = instruction_data_i[I_WIDTH-4-RA_W -: RA_W];
  assign imm      = instruction_data_i[IMM_W-1:0];
  assign imm_sext = {{(D_WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign br_off   = {{(IA_WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign rd_val   = regs_q[rd_a];
  assign rs_val   = regs_q[rs_a];
  // Only the low MA_W bits of rs+sext(imm) matter, so add just those.
  assign mem_ea   = rs_val[MA_W-1:0] + imm_sext[MA_W-1:0];
  assign retry_inc = retry_q + RT_W'(1);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    ld_rd_d        = ld_rd_q;
    we_d           = we_q;
    retry_d        = retry_q;
    error_d        = error_q;
    deque_o        = 1'b0;
    restart_o      = 1'b0;
    restart_addr_o = '0;
    mem_req_o      = 1'b0;
    reg_we         = 1'b0;
    reg_wa         = rd_a;
    reg_wd         = '0;

    case (state_q)
      S_EXEC: begin
        if (instruction_ready_i) begin
          case (op)
            OP_ADD: begin
              reg_we  = 1'b1;
              reg_wd  = rd_val + rs_val;
              deque_o = 1'b1;
            end
            OP_ADDI: begin
              reg_we  = 1'b1;
              reg_wd  = rd_val + imm_sext;
              deque_o = 1'b1;
            end
            OP_LD, OP_ST: begin
              addr_d  = mem_ea;
              wdata_d = rd_val;
              ld_rd_d = rd_a;
              we_d    = (op == OP_ST);
              retry_d = '0;
              state_d = S_MEM_REQ;
            end
            OP_BEQ: begin
              if (rd_val == rs_val) begin
                restart_o      = 1'b1;
                restart_addr_o = instruction_addr_i + br_off;
              end else begin
                deque_o = 1'b1;
              end
            end
            OP_BLT: begin
              if ($signed(rd_val) < $signed(rs_val)) begin
                restart_o      = 1'b1;
                restart_addr_o = instruction_addr_i + br_off;
              end else begin
                deque_o = 1'b1;
              end
            end
            OP_JR: begin
              restart_o      = 1'b1;
              restart_addr_o = rs_val[IA_WIDTH-1:0];
            end
            default: begin  // OP_HALT
              deque_o = 1'b1;
              state_d = S_HALT;
            end
          endcase
        end
      end

      S_MEM_REQ: begin
        mem_req_o = 1'b1;
        if (mem_refused_i) begin
          retry_d = retry_inc;
          if (retry_inc == RT_W'(MAX_RETRY)) begin
            error_d = 1'b1;
            state_d = S_HALT;
          end
        end else if (we_q) begin
          deque_o = 1'b1;
          state_d = S_EXEC;
        end else begin
          state_d = S_MEM_WAIT;
        end
      end

      S_MEM_WAIT: begin
        reg_we  = 1'b1;
        reg_wa  = ld_rd_q;
        reg_wd  = mem_rdata_i;
        deque_o = 1'b1;
        state_d = S_EXEC;
      end

      default: begin  // S_HALT: quiescent until reset
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (reg_we) begin
      regs_d[reg_wa] = reg_wd;
    end
  end

  // A taken restart retires the instruction even though fetch flushes it.
  assign retired_d = retired_q + CNT_W'(deque_o | restart_o);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_EXEC;
      addr_q    <= '0;
      wdata_q   <= '0;
      ld_rd_q   <= '0;
      we_q      <= 1'b0;
      retry_q   <= '0;
      error_q   <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ld_rd_q   <= ld_rd_d;
      we_q      <= we_d;
      retry_q   <= retry_d;
      error_q   <= error_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign dbg_rd_o    = regs_q[dbg_ra_i];
  assign halted_o    = (state_q == S_HALT);
  assign error_o     = error_q;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_backend_seq.sv
// ---------------------------------------------------------------------------
// tb_backend_seq
//   Directed scoreboard bench for backend_seq. The stimulus thread plays the
//   fetch unit and pushes the handshake events each instruction must cause;
//   a monitor on the falling edge pops and compares every deque, restart and
//   accepted memory request. A small memory model answers loads and can be
//   told to refuse a given number of times per request.
// ---------------------------------------------------------------------------
module tb_backend_seq;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [11:0] instruction_data_i;
  logic [7:0]  instruction_addr_i;
  logic        instruction_ready_i;
  logic        deque_o, restart_o;
  logic [7:0]  restart_addr_o;
  logic        mem_req_o, mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i;
  logic        mem_refused_i;
  logic [2:0]  dbg_ra_i;
  logic [15:0] dbg_rd_o;
  logic        halted_o, error_o;
  logic [15:0] retired_o;

  backend_seq dut (
    .clk                 (clk),
    .reset_i             (reset_i),
    .instruction_data_i  (instruction_data_i),
    .instruction_addr_i  (instruction_addr_i),
    .instruction_ready_i (instruction_ready_i),
    .deque_o             (deque_o),
    .restart_o           (restart_o),
    .restart_addr_o      (restart_addr_o),
    .mem_req_o           (mem_req_o),
    .mem_we_o            (mem_we_o),
    .mem_addr_o          (mem_addr_o),
    .mem_wdata_o         (mem_wdata_o),
    .mem_rdata_i         (mem_rdata_i),
    .mem_refused_i       (mem_refused_i),
    .dbg_ra_i            (dbg_ra_i),
    .dbg_rd_o            (dbg_rd_o),
    .halted_o            (halted_o),
    .error_o             (error_o),
    .retired_o           (retired_o)
  );

  always #5 clk = ~clk;

  // kind: 0 deque, 1 restart, 2 store accepted, 3 load accepted
  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic push(input int kind, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = kind; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // ---------------- memory model with per-request refusal budget --------
  logic [15:0] mem [1024];
  int          refuse_budget = 0;
  int          refused_cnt = 0;

  assign mem_refused_i = mem_req_o && (refused_cnt < refuse_budget);

  always @(posedge clk) begin
    if (!mem_req_o) refused_cnt <= 0;
    else if (mem_refused_i) refused_cnt <= refused_cnt + 1;
    if (mem_req_o && !mem_refused_i) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      else mem_rdata_i <= mem[mem_addr_o];
    end
  end

  // ---------------- monitor ----------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (!reset_i) begin
      if (deque_o && restart_o) chk("deque_and_restart", 1, 0);
      if (mem_req_o && !mem_refused_i) begin
        if (exp_q.size() == 0) chk("unexpected_mem", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("mem_kind", mem_we_o ? 2 : 3, e.kind);
          chk("mem_addr", mem_addr_o, e.a);
          if (mem_we_o) chk("mem_wdata", mem_wdata_o, e.d);
        end
      end
      if (restart_o) begin
        if (exp_q.size() == 0) chk("unexpected_restart", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("restart_kind", 1, e.kind);
          chk("restart_addr", restart_addr_o, e.a);
        end
      end
      if (deque_o) begin
        if (exp_q.size() == 0) chk("unexpected_deque", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("deque_kind", 0, e.kind);
        end
      end
    end
  end

  // ---------------- fetch-side driver ------------------------------------
  // Present an instruction until it is dequeued, restarted, or the core halts.
  task automatic issue(input logic [11:0] ins, input logic [7:0] addr);
    bit done = 0;
    instruction_data_i  = ins;
    instruction_addr_i  = addr;
    instruction_ready_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (deque_o || restart_o) begin
        @(posedge clk); #1;
        done = 1;
      end else if (halted_o) begin
        done = 1;
      end
    end
    if (!done) chk("issue_timeout", 1, 0);
    instruction_ready_i = 1'b0;
    $display("issued ins=0x%03h at 0x%02h retired=%0d", ins, addr, retired_o);
  endtask

  task automatic chk_reg(input string name, input logic [2:0] ra, input logic [15:0] req);
    dbg_ra_i = ra;
    #0;
    #1;
    chk(name, dbg_rd_o, req);
  endtask

  function automatic logic [11:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] imm);
    return {op, rd, rs, imm};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b1;
    instruction_data_i = '0;
    instruction_addr_i = '0;
    instruction_ready_i = 1'b0;
    dbg_ra_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_retired", retired_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    reset_i = 1'b0;

    // ADDI r1,+3 ; ADD r1,r1 -> r1=6
    push(0, 0, 0); issue(enc(3'b001, 3'd1, 3'd0, 3'd3), 8'h00);
    push(0, 0, 0); issue(enc(3'b000, 3'd1, 3'd1, 3'd0), 8'h01);
    chk_reg("r1_add", 3'd1, 16'd6);
    chk("retired_2", retired_o, 2);

    // r2 = r3 = 5
    push(0, 0, 0); issue(enc(3'b001, 3'd2, 3'd0, 3'd3), 8'h02);
    push(0, 0, 0); issue(enc(3'b001, 3'd2, 3'd0, 3'd2), 8'h03);
    push(0, 0, 0); issue(enc(3'b001, 3'd3, 3'd0, 3'd3), 8'h04);
    push(0, 0, 0); issue(enc(3'b001, 3'd3, 3'd0, 3'd2), 8'h05);
    chk_reg("r2_5", 3'd2, 16'd5);

    // BEQ r2,r3,-2 at 0x10 -> restart 0x0E
    push(1, 16'h0E, 0); issue(enc(3'b100, 3'd2, 3'd3, 3'b110), 8'h10);
    chk("retired_beq", retired_o, 7);
    // BLT r2,r3 not taken
    push(0, 0, 0); issue(enc(3'b101, 3'd2, 3'd3, 3'd1), 8'h11);
    // r5 = -4 ; BLT r5,r2,+3 at 0x20 -> signed taken, restart 0x23
    push(0, 0, 0); issue(enc(3'b001, 3'd5, 3'd0, 3'b100), 8'h12);
    chk_reg("r5_neg", 3'd5, 16'hFFFC);
    push(1, 16'h23, 0); issue(enc(3'b101, 3'd5, 3'd2, 3'd3), 8'h20);

    // ST r1 -> M[r2+1]=M[6]; LD r4 <- M[6]
    push(2, 16'd6, 16'd6); push(0, 0, 0); issue(enc(3'b011, 3'd1, 3'd2, 3'd1), 8'h21);
    push(3, 16'd6, 0);     push(0, 0, 0); issue(enc(3'b010, 3'd4, 3'd2, 3'd1), 8'h22);
    chk_reg("r4_load", 3'd4, 16'd6);

    // JR r1 -> restart 6
    push(1, 16'd6, 0); issue(enc(3'b110, 3'd0, 3'd1, 3'd0), 8'h23);

    // Two refusals then accept: ST r3 -> M[7]; LD r6 <- M[7]
    refuse_budget = 2;
    push(2, 16'd7, 16'd5); push(0, 0, 0); issue(enc(3'b011, 3'd3, 3'd2, 3'd2), 8'h30);
    chk("retry_error", error_o, 0);
    refuse_budget = 0;
    push(3, 16'd7, 0); push(0, 0, 0); issue(enc(3'b010, 3'd6, 3'd2, 3'd2), 8'h31);
    chk_reg("r6_load", 3'd6, 16'd5);
    chk("retired_15", retired_o, 15);

    // Four refusals -> error and halt, nothing retired
    refuse_budget = 4;
    issue(enc(3'b011, 3'd1, 3'd2, 3'd0), 8'h32);
    @(negedge clk);
    chk("exh_error", error_o, 1);
    chk("exh_halted", halted_o, 1);
    chk("exh_mem_req", mem_req_o, 0);
    chk("exh_retired", retired_o, 15);
    refuse_budget = 0;

    // Reset clears everything
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    chk("rst2_error", error_o, 0);
    chk("rst2_halted", halted_o, 0);
    chk("rst2_retired", retired_o, 0);
    chk_reg("rst2_r1", 3'd1, 16'd0);

    // Reset mid MEM_REQ drops mem_req_o and clears regs without a clock edge
    push(0, 0, 0); issue(enc(3'b001, 3'd1, 3'd0, 3'd3), 8'h40);
    refuse_budget = 100;
    instruction_data_i  = enc(3'b011, 3'd1, 3'd2, 3'd0);
    instruction_addr_i  = 8'h41;
    instruction_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreq_req_before", mem_req_o, 1);
    dbg_ra_i = 3'd1;
    #2 reset_i = 1'b1;
    #1;
    chk("midreq_req_after", mem_req_o, 0);
    chk("midreq_r1", dbg_rd_o, 0);
    instruction_ready_i = 1'b0;
    refuse_budget = 0;
    @(posedge clk); #1;
    reset_i = 1'b0;

    // HALT then fetch is ignored
    push(0, 0, 0); issue(enc(3'b111, 3'd0, 3'd0, 3'd0), 8'h50);
    chk("halt_halted", halted_o, 1);
    instruction_data_i  = enc(3'b001, 3'd1, 3'd0, 3'd3);
    instruction_addr_i  = 8'h51;
    instruction_ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    instruction_ready_i = 1'b0;
    chk_reg("halt_r1", 3'd1, 16'd0);
    chk("halt_retired", retired_o, 1);
    chk("halt_error", error_o, 0);

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
